// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 codes, unit FSM encoding and constants.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] XLEN_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] XLEN_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator, radix-2 shift-add / restoring-divide step and sign fix-up.
module muldiv_datapath
  import riscv_m_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        special_c,
  output logic [31:0] result_c
);

  logic [2:0]  f3_q;
  logic [63:0] acc_q;
  logic [31:0] oper_q;
  logic        neg_q;
  logic        spec_q;
  logic [31:0] spec_val_q;

  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [31:0] spec_val;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] acc_next, mul_p;
  logic [31:0] quo, rem;

  // Operand signs/magnitudes and the cases that skip iteration entirely.
  always_comb begin
    sign_a    = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU) && op_a[31];
    sign_b    = ((funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                 (funct3 == F3_REM)) && op_b[31];
    mag_a     = sign_a ? 32'(-op_a) : op_a;
    mag_b     = sign_b ? 32'(-op_b) : op_b;
    special_c = 1'b0;
    spec_val  = '0;
    if (funct3[2] && (op_b == '0)) begin
      special_c = 1'b1;
      spec_val  = funct3[1] ? op_a : XLEN_ONES;
    end else if (((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == XLEN_MIN) && (op_b == XLEN_ONES)) begin
      special_c = 1'b1;
      spec_val  = funct3[1] ? 32'h0 : XLEN_MIN;
    end
  end

  // Multiply keeps the multiplier in acc[31:0]; divide keeps dividend/quotient there.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? oper_q : 32'h0)};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, oper_q};
    if (f3_q[2]) begin
      acc_next = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                              : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc_q[31:1]};
    end
  end

  always_comb begin
    mul_p = neg_q ? 64'(-acc_q) : acc_q;
    quo   = neg_q ? 32'(-acc_q[31:0]) : acc_q[31:0];
    rem   = neg_q ? 32'(-acc_q[63:32]) : acc_q[63:32];
    if (spec_q) begin
      result_c = spec_val_q;
    end else if (!f3_q[2]) begin
      result_c = (f3_q == F3_MUL) ? mul_p[31:0] : mul_p[63:32];
    end else begin
      result_c = f3_q[1] ? rem : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q       <= '0;
      acc_q      <= '0;
      oper_q     <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else if (load) begin
      f3_q       <= funct3;
      spec_q     <= special_c;
      spec_val_q <= spec_val;
      neg_q      <= (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
      if (funct3[2]) begin
        acc_q  <= {32'h0, mag_a};
        oper_q <= mag_b;
      end else begin
        acc_q  <= {32'h0, mag_b};
        oper_q <= mag_a;
      end
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a one-cycle register-file writeback.
module riscv_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITER_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            wb_enable,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [4:0]        rd_q, rd_d;
  logic              busy_d, wbe_d;
  logic [4:0]        wb_addr_d;
  logic [XLEN-1:0]   wb_data_d;
  logic              load_c, step_c, special_c;
  logic [XLEN-1:0]   result_c;

  muldiv_datapath u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .step      (step_c),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .special_c (special_c),
    .result_c  (result_c)
  );

  // Next-state and registered-output logic; kill always wins over progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wbe_d     = 1'b0;
    wb_addr_d = wb_addr;
    wb_data_d = wb_data;
    load_c    = 1'b0;
    step_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !kill) begin
          load_c  = 1'b1;
          rd_d    = rd_addr;
          cnt_d   = '0;
          state_d = special_c ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else begin
          step_c = 1'b1;
          cnt_d  = cnt_q + ITER_W'(1);
          if (cnt_q == ITER_W'(31)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!kill && (rd_q != 5'd0)) begin
          wbe_d     = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = result_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      busy      <= 1'b0;
      wb_enable <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      busy      <= busy_d;
      wb_enable <= wbe_d;
      wb_addr   <= wb_addr_d;
      wb_data   <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed self-checking bench for riscv_muldiv_unit.
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_addr;
  logic        busy, wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .kill      (kill),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .wb_enable (wb_enable),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, accepted at edge N; expects the write strobe after edge N+lat.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int lat,
                        input logic exp_wb, input logic [31:0] exp_d, input bit mid_pulse);
    int early;
    early = 0;
    tick();
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_addr = rd;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) begin
        early += int'(wb_enable);
        if (k == lat - 1) check({tag, "_busy_end"}, 32'(busy), 32'd1);
        if (mid_pulse && k == 4) begin
          start = 1'b1; funct3 = 3'b101; op_a = 32'd1; op_b = 32'd0; rd_addr = 5'd9;
        end
        if (k == 5) start = 1'b0;
      end
    end
    check({tag, "_early_wb"}, 32'(early), 32'd0);
    check({tag, "_wb_en"}, 32'(wb_enable), 32'(exp_wb));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    if (exp_wb) begin
      check({tag, "_wb_addr"}, 32'(wb_addr), 32'(rd));
      check({tag, "_wb_data"}, wb_data, exp_d);
    end
    tick();
    check({tag, "_wb_pulse"}, 32'(wb_enable), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0; rd_addr = '0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb_en", 32'(wb_enable), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  33, 1'b1, 32'hFFFF_FFEB, 1'b1);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  33, 1'b1, 32'h4000_0000, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  33, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  33, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  33, 1'b1, 32'hFFFF_FFFD, 1'b0);
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 33, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",   3'b101, 32'd100,       32'd7,         5'd11, 33, 1'b1, 32'd14,        1'b0);
    run_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 33, 1'b1, 32'd2,         1'b0);
    run_op("divu0",  3'b101, 32'd5,         32'd0,         5'd13, 1,  1'b1, 32'hFFFF_FFFF, 1'b0);
    run_op("rem0",   3'b110, 32'd5,         32'd0,         5'd14, 1,  1'b1, 32'd5,         1'b0);
    run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1,  1'b1, 32'h8000_0000, 1'b0);
    run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1,  1'b1, 32'd0,         1'b0);

    // start together with kill in IDLE is refused
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1; rd_addr = 5'd3;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill_idle_busy", 32'(busy), 32'd0);

    // kill at CALC iteration 10, with an ignored start pulse before it
    start = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9; rd_addr = 5'd20;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) begin
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1; op_b = 32'd0;
      end
      if (k == 4) start = 1'b0;
    end
    check("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_wb_en", 32'(wb_enable), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen += int'(wb_enable);
    end
    check("kill_no_wb", 32'(seen), 32'd0);

    run_op("mul3x4", 3'b000, 32'd3, 32'd4, 5'd21, 33, 1'b1, 32'd12, 1'b0);
    run_op("mul_x0", 3'b000, 32'd2, 32'd2, 5'd0,  33, 1'b0, 32'd0,  1'b0);
    check("x0_hold_addr", 32'(wb_addr), 32'd21);

    // synchronous reset mid-CALC discards the op
    start = 1'b1; funct3 = 3'b100; op_a = 32'd50; op_b = 32'd5; rd_addr = 5'd22;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_wb_en", 32'(wb_enable), 32'd0);
    check("rstmid_wb_addr", 32'(wb_addr), 32'd0);
    check("rstmid_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      seen += int'(wb_enable) + int'(busy);
    end
    check("rstmid_quiet", 32'(seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
